pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Supervises the pixel-clock rPLL: drives its reset, waits for and qualifies lock, then releases the video-domain reset.
- Retries PLL startup on lock timeout and re-sequences on lock loss during operation.
- Latches a fault after repeated failures.
- Runs on the 27 MHz reference clock, between board reset and the 480p pixel-clock generator / video pipeline reset tree.

Parameters:
RST_HOLD_CYCLES, 27, cycles PLL_RESET is held high per attempt (1 us at 27 MHz); must be >= 1
LOCK_TIMEOUT_CYCLES, 2700000, max cycles to wait for lock after PLL reset release (100 ms)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before declaring lock good
MAX_RETRIES, 3, lock timeouts tolerated before entering FAULT; 1..15

Ports:
C27M  in  1  27 MHz reference clock; sole clock
RESET  in  1  asynchronous, active-high reset
PLOCK  in  1  PLL lock, asynchronous to C27M
PLL_RESET  out  1  active-high reset to rPLL
VIDEO_RESET  out  1  active-high reset for pixel-domain logic; consumer synchronizes it into PCLK
READY  out  1  high while lock qualified and video running
FAULT  out  1  retries exhausted; sticky until RESET
RETRY_COUNT  out  4  lock timeouts since last successful lock
LOSS_COUNT  out  8  lock-loss events while in RUN; saturates at 255

Behaviour:
- PLOCK passes a 2-FF synchronizer (lock_s). Sync flops reset to 0. All decisions use lock_s, which lags PLOCK by 2 cycles.
- Single counter cnt, width $clog2 of the largest cycle parameter + 1. Cleared on every state change.
- Outputs are registered Moore decodes of the state register; they change on the same edge as the state.
- RESET asserted (async): state=HOLD, cnt=0, PLL_RESET=1, VIDEO_RESET=1, READY=0, FAULT=0, RETRY_COUNT=0, LOSS_COUNT=0. Mid-operation RESET aborts any state immediately.
- HOLD:
  - PLL_RESET=1, VIDEO_RESET=1.
  - cnt counts 0..RST_HOLD_CYCLES-1. At terminal count -> WAIT_LOCK.
  - PLL_RESET is high for exactly RST_HOLD_CYCLES cycles per entry.
- WAIT_LOCK:
  - PLL_RESET=0, VIDEO_RESET=1.
  - lock_s=1 -> STABLE.
  - Otherwise cnt increments. At cnt=LOCK_TIMEOUT_CYCLES-1 with lock_s=0 it is a timeout:
    - if RETRY_COUNT+1 >= MAX_RETRIES -> FAULT, with RETRY_COUNT=MAX_RETRIES;
    - else RETRY_COUNT++ -> HOLD.
  - lock_s rising on the timeout cycle: lock wins, -> STABLE.
- STABLE:
  - PLL_RESET=0, VIDEO_RESET=1.
  - lock_s=0 -> WAIT_LOCK, cnt restarted; glitch is not counted as a retry.
  - cnt reaching LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN; RETRY_COUNT cleared on this edge.
- RUN:
  - PLL_RESET=0, VIDEO_RESET=0, READY=1.
  - lock_s=0 -> HOLD on that edge: VIDEO_RESET=1, READY=0 simultaneously.
  - LOSS_COUNT++ (saturating at 255); RETRY_COUNT unchanged.
- FAULT:
  - PLL_RESET=1, VIDEO_RESET=1, READY=0, FAULT=1.
  - PLOCK ignored. Exit only via RESET.
- LOSS_COUNT is cleared only by RESET.
- VIDEO_RESET=0 implies READY=1 and PLL_RESET=0, in every cycle.

Test Plan (sim params RST_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=16, MAX_RETRIES=2):
1. Clean start: RESET pulse, PLOCK rises 10 cycles after PLL_RESET falls and stays high -> PLL_RESET high exactly 4 cycles; READY rises 2+16 cycles after PLOCK rises; VIDEO_RESET falls the same edge; RETRY_COUNT=0.
2. One timeout: PLOCK low for the first attempt, high 5 cycles into the second WAIT_LOCK -> RETRY_COUNT=1 during the second attempt, second 4-cycle PLL_RESET pulse seen, READY=1, RETRY_COUNT=0 after lock.
3. Fault: PLOCK held low -> two timeouts, FAULT=1, RETRY_COUNT=2, PLL_RESET stays 1; later PLOCK high does not clear FAULT; RESET clears everything.
4. Lock glitch in STABLE: PLOCK drops 1 cycle after 8 stable cycles -> returns to WAIT_LOCK, RETRY_COUNT unchanged, READY rises only after a fresh 16-cycle stable window.
5. Loss in RUN: after READY=1, drop PLOCK -> 2 cycles later VIDEO_RESET=1, READY=0, LOSS_COUNT=1, PLL_RESET pulses 4 cycles; relock restores READY. Repeat 300 times -> LOSS_COUNT=255.
6. Async reset mid-STABLE: assert RESET between clock edges -> PLL_RESET=1, VIDEO_RESET=1, all counters 0 without waiting for an edge; sequence restarts at HOLD after release.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer, the rPLL and the pixel-domain reset tree.
// master: the sequencer. slave: the PLL / video side, or a testbench standing in for them.
interface pll_lock_sequencer_if;
   logic       PLOCK;
   logic       PLL_RESET;
   logic       VIDEO_RESET;
   logic       READY;
   logic       FAULT;
   logic [3:0] RETRY_COUNT;
   logic [7:0] LOSS_COUNT;

   modport master (
      input  PLOCK,
      output PLL_RESET, VIDEO_RESET, READY, FAULT, RETRY_COUNT, LOSS_COUNT
   );

   modport slave (
      output PLOCK,
      input  PLL_RESET, VIDEO_RESET, READY, FAULT, RETRY_COUNT, LOSS_COUNT
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Supervises the pixel-clock rPLL: pulses its reset, qualifies lock, then releases the
// video-domain reset. Retries on lock timeout, re-sequences on lock loss, latches a fault.
module pll_lock_sequencer #(
   parameter int unsigned RST_HOLD_CYCLES     = 27,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 2700000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                 C27M,
   input  logic                 RESET,
   pll_lock_sequencer_if.master bus
);

   localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);
   localparam logic [4:0]       RETRY_LIMIT  = 5'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   typedef struct packed {
      logic pll_reset;
      logic video_reset;
      logic ready;
      logic fault;
   } outs_t;

   // Moore output decode, applied on the same edge that loads the new state.
   function automatic outs_t decode(input state_t s);
      outs_t o;
      o = '{pll_reset: 1'b0, video_reset: 1'b1, ready: 1'b0, fault: 1'b0};
      case (s)
         S_HOLD:  o.pll_reset = 1'b1;
         S_RUN:   begin o.video_reset = 1'b0; o.ready = 1'b1; end
         S_FAULT: begin o.pll_reset = 1'b1; o.fault = 1'b1; end
         default: ;
      endcase
      return o;
   endfunction

   logic [1:0]       r_sync;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   outs_t            r_outs;
   logic [3:0]       r_retry;
   logic [7:0]       r_loss;
   logic             w_lock_s;
   logic [4:0]       w_retry_inc;

   assign w_lock_s    = r_sync[1];
   assign w_retry_inc = {1'b0, r_retry} + 5'd1;

   always_ff @(posedge C27M or posedge RESET) begin
      if (RESET) begin
         r_sync <= '0;
      end else begin
         // NOTE: non-blocking so the second stage takes the first stage's pre-edge value;
         // a blocking update would collapse the synchronizer to a single flop.
         r_sync <= {r_sync[0], bus.PLOCK};
      end
   end

   always_ff @(posedge C27M or posedge RESET) begin
      if (RESET) begin
         r_state <= S_HOLD;
         r_cnt   <= '0;
         r_outs  <= decode(S_HOLD);
         r_retry <= '0;
         r_loss  <= '0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_state <= S_WAIT_LOCK;
                  r_cnt   <= '0;
                  r_outs  <= decode(S_WAIT_LOCK);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_WAIT_LOCK: begin
               // Lock takes priority over a timeout landing on the same cycle.
               if (w_lock_s) begin
                  r_state <= S_STABLE;
                  r_cnt   <= '0;
                  r_outs  <= decode(S_STABLE);
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_cnt <= '0;
                  if (w_retry_inc >= RETRY_LIMIT) begin
                     r_state <= S_FAULT;
                     r_outs  <= decode(S_FAULT);
                     r_retry <= RETRY_MAX;
                  end else begin
                     r_state <= S_HOLD;
                     r_outs  <= decode(S_HOLD);
                     r_retry <= r_retry + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_STABLE: begin
               if (!w_lock_s) begin
                  r_state <= S_WAIT_LOCK;
                  r_cnt   <= '0;
                  r_outs  <= decode(S_WAIT_LOCK);
               end else if (r_cnt == STABLE_LAST) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
                  r_outs  <= decode(S_RUN);
                  r_retry <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_RUN: begin
               if (!w_lock_s) begin
                  r_state <= S_HOLD;
                  r_cnt   <= '0;
                  r_outs  <= decode(S_HOLD);
                  if (r_loss != 8'hFF) r_loss <= r_loss + 8'd1;
               end
            end

            S_FAULT: ;

            default: begin
               r_state <= S_HOLD;
               r_cnt   <= '0;
               r_outs  <= decode(S_HOLD);
            end
         endcase
      end
   end

   assign bus.PLL_RESET   = r_outs.pll_reset;
   assign bus.VIDEO_RESET = r_outs.video_reset;
   assign bus.READY       = r_outs.ready;
   assign bus.FAULT       = r_outs.fault;
   assign bus.RETRY_COUNT = r_retry;
   assign bus.LOSS_COUNT  = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed and randomized PLOCK waveforms against a
// streak-counting reference model of the lock sequencing rules.
module tb_pll_lock_sequencer;

   localparam int P_HOLD = 4;
   localparam int P_TO   = 64;
   localparam int P_STB  = 16;
   localparam int P_MAX  = 2;

   // Model phases: WAIT_LOCK and STABLE are merged into one acquisition phase.
   localparam int PH_PLLRST = 0;
   localparam int PH_ACQ    = 1;
   localparam int PH_RUN    = 2;
   localparam int PH_DEAD   = 3;

   logic C27M  = 1'b0;
   logic RESET = 1'b0;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES    (P_HOLD),
      .LOCK_TIMEOUT_CYCLES(P_TO),
      .LOCK_STABLE_CYCLES (P_STB),
      .MAX_RETRIES        (P_MAX)
   ) dut (
      .C27M (C27M),
      .RESET(RESET),
      .bus  (bus)
   );

   always #5 C27M = ~C27M;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   int   m_phase, m_hold, m_low, m_high, m_retry, m_loss;
   logic m_h0, m_h1;

   int   pll_fall_cyc, pll_rise_cyc, rdy_rise_cyc, rdy_fall_cyc, vr_fall_cyc;
   logic prev_pll, prev_rdy, prev_vr;
   int   rel_cyc, rise_cyc, drop_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_PLLRST;
      m_hold  = 0;
      m_low   = 0;
      m_high  = 0;
      m_retry = 0;
      m_loss  = 0;
      m_h0    = 1'b0;
      m_h1    = 1'b0;
   endtask

   // lock_s seen at an edge is the PLOCK value sampled two edges earlier.
   task automatic model_edge(input logic pl);
      logic ls;
      ls   = m_h1;
      m_h1 = m_h0;
      m_h0 = pl;
      case (m_phase)
         PH_PLLRST: begin
            m_hold++;
            if (m_hold == P_HOLD) begin
               m_phase = PH_ACQ;
               m_low   = 0;
               m_high  = 0;
            end
         end
         PH_ACQ: begin
            if (ls) begin
               m_high++;
               m_low = 0;
               if (m_high == P_STB + 1) begin
                  m_phase = PH_RUN;
                  m_retry = 0;
               end
            end else if (m_high > 0) begin
               m_high = 0;
            end else begin
               m_low++;
               if (m_low == P_TO) begin
                  if (m_retry + 1 >= P_MAX) begin
                     m_phase = PH_DEAD;
                     m_retry = P_MAX;
                  end else begin
                     m_retry++;
                     m_phase = PH_PLLRST;
                     m_hold  = 0;
                  end
               end
            end
         end
         PH_RUN: begin
            if (!ls) begin
               m_phase = PH_PLLRST;
               m_hold  = 0;
               if (m_loss < 255) m_loss++;
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("pll_reset", 32'(bus.PLL_RESET), 32'(m_phase == PH_PLLRST || m_phase == PH_DEAD));
      check("video_reset", 32'(bus.VIDEO_RESET), 32'(m_phase != PH_RUN));
      check("ready", 32'(bus.READY), 32'(m_phase == PH_RUN));
      check("fault", 32'(bus.FAULT), 32'(m_phase == PH_DEAD));
      check("retry_count", 32'(bus.RETRY_COUNT), 32'(m_retry));
      check("loss_count", 32'(bus.LOSS_COUNT), 32'(m_loss));
      if (bus.VIDEO_RESET === 1'b0)
         check("vr_low_implies", 32'({bus.READY, bus.PLL_RESET}), 32'd2);
   endtask

   // Entered and left at a falling edge; one rising edge per call.
   task automatic step(input logic pl);
      bus.PLOCK = pl;
      @(posedge C27M);
      #1;
      cyc++;
      model_edge(pl);
      compare_all();
      if (prev_pll && !bus.PLL_RESET) pll_fall_cyc = cyc;
      if (!prev_pll && bus.PLL_RESET) pll_rise_cyc = cyc;
      if (!prev_rdy && bus.READY)     rdy_rise_cyc = cyc;
      if (prev_rdy && !bus.READY)     rdy_fall_cyc = cyc;
      if (prev_vr && !bus.VIDEO_RESET) vr_fall_cyc = cyc;
      prev_pll = bus.PLL_RESET;
      prev_rdy = bus.READY;
      prev_vr  = bus.VIDEO_RESET;
      @(negedge C27M);
   endtask

   task automatic steps(input logic pl, input int n);
      for (int i = 0; i < n; i++) step(pl);
   endtask

   // Asserts RESET between edges and checks outputs before any edge arrives.
   task automatic do_reset();
      #2;
      RESET = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge C27M);
      RESET    = 1'b0;
      prev_pll = 1'b1;
      prev_rdy = 1'b0;
      prev_vr  = 1'b1;
      rel_cyc  = cyc;
   endtask

   initial begin
      bus.PLOCK = 1'b0;
      @(negedge C27M);

      // Clean start
      do_reset();
      steps(1'b0, P_HOLD + 10);
      rise_cyc = cyc + 1;
      steps(1'b1, 25);
      check("t1_pll_pulse_len", 32'(pll_fall_cyc - rel_cyc), 32'd4);
      check("t1_ready_latency", 32'(rdy_rise_cyc - rise_cyc), 32'd18);
      check("t1_vr_with_ready", 32'(vr_fall_cyc), 32'(rdy_rise_cyc));
      check("t1_ready", 32'(bus.READY), 32'd1);
      check("t1_retry", 32'(bus.RETRY_COUNT), 32'd0);

      // One timeout, lock on the second attempt
      do_reset();
      steps(1'b0, P_HOLD + P_TO + 2);
      check("t2_retry_mid", 32'(bus.RETRY_COUNT), 32'd1);
      steps(1'b0, 2 + 5);
      check("t2_second_pulse", 32'(pll_fall_cyc - pll_rise_cyc), 32'd4);
      steps(1'b1, 30);
      check("t2_ready", 32'(bus.READY), 32'd1);
      check("t2_retry_cleared", 32'(bus.RETRY_COUNT), 32'd0);

      // Retries exhausted
      do_reset();
      steps(1'b0, 2 * (P_HOLD + P_TO) + 4);
      check("t3_fault", 32'(bus.FAULT), 32'd1);
      check("t3_retry", 32'(bus.RETRY_COUNT), 32'd2);
      check("t3_pll_reset", 32'(bus.PLL_RESET), 32'd1);
      steps(1'b1, 30);
      check("t3_fault_sticky", 32'(bus.FAULT), 32'd1);
      check("t3_no_ready", 32'(bus.READY), 32'd0);
      do_reset();
      check("t3_fault_cleared", 32'(bus.FAULT), 32'd0);

      // Lock glitch during the stable window
      steps(1'b0, P_HOLD);
      steps(1'b1, 10);
      steps(1'b0, 1);
      rise_cyc = cyc + 1;
      steps(1'b1, 30);
      check("t4_fresh_window", 32'(rdy_rise_cyc - rise_cyc), 32'd18);
      check("t4_retry", 32'(bus.RETRY_COUNT), 32'd0);

      // Lock loss in RUN, then saturation of the loss counter
      drop_cyc = cyc + 1;
      steps(1'b0, 2);
      steps(1'b1, 30);
      check("t5_ready_fall", 32'(rdy_fall_cyc - drop_cyc), 32'd2);
      check("t5_pulse", 32'(pll_fall_cyc - pll_rise_cyc), 32'd4);
      check("t5_loss1", 32'(bus.LOSS_COUNT), 32'd1);
      check("t5_relock", 32'(bus.READY), 32'd1);
      for (int k = 0; k < 299; k++) begin
         steps(1'b0, int'($urandom_range(1, 3)));
         steps(1'b1, 30);
      end
      check("t5_loss_sat", 32'(bus.LOSS_COUNT), 32'd255);
      check("t5_ready_end", 32'(bus.READY), 32'd1);

      // Async reset in the middle of the stable window
      do_reset();
      steps(1'b0, P_HOLD);
      steps(1'b1, 10);
      do_reset();
      check("t6_loss_zero", 32'(bus.LOSS_COUNT), 32'd0);
      steps(1'b0, P_HOLD);
      check("t6_restart_pulse", 32'(pll_fall_cyc - rel_cyc), 32'd4);

      // Randomized PLOCK waveforms against the model
      for (int s = 0; s < 60; s++) begin
         if (m_phase == PH_DEAD && $urandom_range(0, 1) == 1) do_reset();
         steps(1'(s % 2), int'($urandom_range(1, 90)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
